reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//   Sits directly downstream of the reset debouncer in the ADC capture FPGA.
//   Takes the debounced active-low reset request and the PLL/MMCM lock status,
//   then releases the per-stage resets of the capture pipeline in a fixed order
//   (clocking -> ADC interface -> capture FIFO -> host logic), spaced in time.
//   Also detects lock timeouts, retries a bounded number of times, and flags a
//   fault.
// PARAMETERS
//   NUM_STAGES   4     number of sequenced reset outputs, released LSB first
//   STAGE_GAP    64    clk cycles between successive stage releases (>=1)
//   LOCK_TIMEOUT 1024  clk cycles to wait for lock per attempt (>=1)
//   MAX_RETRIES  3     timeout retries before FAULT (0..15)
//   CNT_W        16    width of gap/timeout counters; STAGE_GAP, LOCK_TIMEOUT < 2**CNT_W
// PORTS
//   clk         in   1           system clock
//   rst         in   1           synchronous, active-high reset
//   rstn_db     in   1           debounced active-low reset request from debouncer, clk domain
//   pll_locked  in   1           PLL lock, asynchronous; 2-flop synchronised internally
//   stage_rst   out  NUM_STAGES  active-high reset per stage; bit i released i-th
//   seq_done    out  1           all stages released, lock held
//   seq_fault   out  1           lock not achieved after MAX_RETRIES retries
//   retry_cnt   out  4           timeouts seen this sequence, saturates at MAX_RETRIES
//   state_dbg   out  3           IDLE=0 WAIT_LOCK=1 RELEASE=2 DONE=3 FAULT=4
// BEHAVIOUR
//   - All outputs are registered. Under rst: state IDLE, stage_rst all 1, seq_done 0,
//     seq_fault 0, retry_cnt 0, counters 0, sync flops 0.
//   - locked_s = pll_locked through 2 flops, so lock is seen 2 cycles late.
//   - Priority, highest first: rst > rstn_db==0 > loss of locked_s > timeout/gap events.
//   - rstn_db==0 in any state: next state IDLE, stage_rst all 1, seq_done 0,
//     seq_fault 0, retry_cnt 0.
//   - IDLE: hold all stages in reset. When rstn_db==1, go to WAIT_LOCK with timer=0.
//   - WAIT_LOCK: timer increments every cycle.
//     If locked_s==1, go to RELEASE with idx=0 and gap=0.
//     Else, when timer==LOCK_TIMEOUT-1:
//       if retry_cnt<MAX_RETRIES, retry_cnt++ and timer=0 (stay in WAIT_LOCK);
//       otherwise go to FAULT.
//   - RELEASE: gap counts 0..STAGE_GAP-1. On terminal count, clear stage_rst[idx],
//     idx++, gap=0. Stage i deasserts (i+1)*STAGE_GAP cycles after RELEASE entry.
//     On the edge that clears stage_rst[NUM_STAGES-1], state becomes DONE and
//     seq_done goes 1 on that same edge.
//   - DONE: stage_rst all 0, seq_done 1.
//   - locked_s==0 in RELEASE or DONE: next cycle stage_rst all 1 and seq_done 0;
//     go to WAIT_LOCK with timer=0. retry_cnt is kept.
//   - FAULT: stage_rst all 1, seq_fault 1. Sticky: exits only via rst or rstn_db==0.
//   - Stage outputs only go 1->0 in ascending order. Any re-assertion sets all bits
//     to 1 at once. stage_rst is never a partial non-thermometer pattern.
// TESTING (defaults unless noted)
//   1. rst 4 cycles, then rstn_db=1 and pll_locked=1 held
//      -> stage_rst 1111->1110->1100->1000->0000, steps 64 cycles apart;
//      seq_done=1 with the last step; retry_cnt=0.
//   2. pll_locked=0 forever
//      -> retry_cnt 1,2,3 at 1024/2048/3072 cycles after WAIT_LOCK entry;
//      seq_fault=1 and state_dbg=4 at 4096; stage_rst stays 1111.
//   3. Locked; drop pll_locked 10 cycles after stage_rst=1100
//      -> stage_rst=1111 three cycles after the drop (2 sync + 1);
//      relock restarts from 1111 with full 64-cycle gaps.
//   4. rstn_db low for 1 cycle mid-RELEASE, with retry_cnt=2 from an earlier timeout
//      -> state IDLE, stage_rst 1111, retry_cnt 0; sequence restarts when rstn_db=1.
//   5. STAGE_GAP=1, lock held -> stage_rst drops one bit per cycle; DONE 4 cycles
//      after RELEASE entry.
//   6. From FAULT: rstn_db 0 then 1 with pll_locked=1
//      -> seq_fault clears on the first cycle of rstn_db=0; normal sequence then completes.

Source files
------------

// File: rtl/reset_sequencer.sv
// Releases per-stage pipeline resets in ascending order once the PLL reports lock,
// with lock-timeout retries and a sticky fault.
module reset_sequencer #(
   parameter int unsigned NUM_STAGES   = 4,
   parameter int unsigned STAGE_GAP    = 64,
   parameter int unsigned LOCK_TIMEOUT = 1024,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_rstn_db,
   input  logic                  i_pll_locked,
   output logic [NUM_STAGES-1:0] o_stage_rst,
   output logic                  o_seq_done,
   output logic                  o_seq_fault,
   output logic [3:0]            o_retry_cnt,
   output logic [2:0]            o_state_dbg
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StWaitLock = 3'd1;
   localparam logic [2:0] StRelease  = 3'd2;
   localparam logic [2:0] StDone     = 3'd3;
   localparam logic [2:0] StFault    = 3'd4;

   localparam logic [CNT_W-1:0] GapLast     = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

   logic                  r_sync1;
   logic                  r_sync2;
   logic [2:0]            r_state;
   logic [NUM_STAGES-1:0] r_stage_rst;
   logic                  r_seq_done;
   logic                  r_seq_fault;
   logic [3:0]            r_retry_cnt;
   logic [CNT_W-1:0]      r_timer;
   logic [CNT_W-1:0]      r_gap;

   logic                  w_locked;
   logic [2:0]            w_state_d;
   logic [NUM_STAGES-1:0] w_stage_d;
   logic [NUM_STAGES-1:0] w_stage_next;
   logic                  w_done_d;
   logic                  w_fault_d;
   logic [3:0]            w_retry_d;
   logic [CNT_W-1:0]      w_timer_d;
   logic [CNT_W-1:0]      w_gap_d;

   assign w_locked = r_sync2;
   // Shifting in a zero keeps the stage vector a thermometer code by construction.
   assign w_stage_next = r_stage_rst << 1;

   always_comb begin
      w_state_d = r_state;
      w_stage_d = r_stage_rst;
      w_done_d  = r_seq_done;
      w_fault_d = r_seq_fault;
      w_retry_d = r_retry_cnt;
      w_timer_d = r_timer;
      w_gap_d   = r_gap;
      if (!i_rstn_db) begin
         w_state_d = StIdle;
         w_stage_d = '1;
         w_done_d  = 1'b0;
         w_fault_d = 1'b0;
         w_retry_d = 4'd0;
         w_timer_d = '0;
         w_gap_d   = '0;
      end else begin
         case (r_state)
            StIdle: begin
               w_stage_d = '1;
               w_done_d  = 1'b0;
               w_state_d = StWaitLock;
               w_timer_d = '0;
            end
            StWaitLock: begin
               w_stage_d = '1;
               w_done_d  = 1'b0;
               if (w_locked) begin
                  w_state_d = StRelease;
                  w_gap_d   = '0;
               end else if (r_timer == TimeoutLast) begin
                  if (r_retry_cnt < RetryMax) begin
                     w_retry_d = r_retry_cnt + 4'd1;
                     w_timer_d = '0;
                  end else begin
                     w_state_d = StFault;
                     w_fault_d = 1'b1;
                  end
               end else begin
                  w_timer_d = r_timer + CNT_W'(1);
               end
            end
            StRelease, StDone: begin
               if (!w_locked) begin
                  w_state_d = StWaitLock;
                  w_stage_d = '1;
                  w_done_d  = 1'b0;
                  w_timer_d = '0;
               end else if (r_state == StRelease) begin
                  if (r_gap == GapLast) begin
                     w_stage_d = w_stage_next;
                     w_gap_d   = '0;
                     if (w_stage_next == '0) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                     end
                  end else begin
                     w_gap_d = r_gap + CNT_W'(1);
                  end
               end
            end
            StFault: begin
               w_stage_d = '1;
               w_done_d  = 1'b0;
               w_fault_d = 1'b1;
            end
            default: begin
               w_state_d = StIdle;
               w_stage_d = '1;
               w_done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_state     <= StIdle;
         r_stage_rst <= '1;
         r_seq_done  <= 1'b0;
         r_seq_fault <= 1'b0;
         r_retry_cnt <= 4'd0;
         r_timer     <= '0;
         r_gap       <= '0;
      end else begin
         r_sync1     <= i_pll_locked;
         r_sync2     <= r_sync1;
         r_state     <= w_state_d;
         r_stage_rst <= w_stage_d;
         r_seq_done  <= w_done_d;
         r_seq_fault <= w_fault_d;
         r_retry_cnt <= w_retry_d;
         r_timer     <= w_timer_d;
         r_gap       <= w_gap_d;
      end
   end

   assign o_stage_rst = r_stage_rst;
   assign o_seq_done  = r_seq_done;
   assign o_seq_fault = r_seq_fault;
   assign o_retry_cnt = r_retry_cnt;
   assign o_state_dbg = r_state;

endmodule
